// File: rtl/nibbler_pkg.sv
// Shared types for the nibbler core: opcodes, FSM states, ALU selects and
// opcode-class helpers.
package nibbler_pkg;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_CMPI = 4'h2,
        OP_CMPM = 4'h3,
        OP_LIT  = 4'h4,
        OP_IN   = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JZ   = 4'h8,
        OP_JNZ  = 4'h9,
        OP_ADDI = 4'hA,
        OP_ADDM = 4'hB,
        OP_JMP  = 4'hC,
        OP_OUT  = 4'hD,
        OP_NORI = 4'hE,
        OP_NORM = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_NOR = 2'd1,
        ALU_CMP = 2'd2
    } alu_op_e;

    function automatic logic is_mem(input opcode_e op);
        return op inside {OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NORM};
    endfunction

    function automatic logic is_jump(input opcode_e op);
        return op inside {OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP};
    endfunction

    function automatic alu_op_e alu_op_of(input opcode_e op);
        alu_op_e sel;
        case (op)
            OP_ADDI, OP_ADDM: sel = ALU_ADD;
            OP_NORI, OP_NORM: sel = ALU_NOR;
            default:          sel = ALU_CMP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/nibbler_if.sv
// Program-memory and data-RAM bus of the nibbler core; master is the core.
interface nibbler_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] prog_addr;
    logic [ADDR_W+3:0] prog_word;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_re;
    logic              ram_we;
    logic              ram_ready;

    modport master (
        output prog_addr, ram_addr, ram_wdata, ram_re, ram_we,
        input  prog_word, ram_rdata, ram_ready
    );

    modport slave (
        input  prog_addr, ram_addr, ram_wdata, ram_re, ram_we,
        output prog_word, ram_rdata, ram_ready
    );
endinterface

// File: rtl/nibbler_alu.sv
// Combinational ALU: ADD with carry-out, NOR, and unsigned compare.
module nibbler_alu
    import nibbler_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] nor_v;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign nor_v = ~(a | b);

    // CMP leaves the accumulator as-is: carry means a >= b, zero means a == b.
    always_comb begin
        result = a;
        carry  = 1'b0;
        zero   = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                zero   = (sum[DATA_W-1:0] == '0);
            end
            ALU_NOR: begin
                result = nor_v;
                zero   = (nor_v == '0);
            end
            default: begin
                result = a;
                carry  = (a >= b);
                zero   = (a == b);
            end
        endcase
    end

endmodule

// File: rtl/nibbler_core.sv
// Nibbler 4-bit accumulator core: two-cycle FETCH/EXEC sequencing with RAM
// wait states and a halt handshake.
//
//   state | meaning
//   FETCH | latch program word into instr/operand
//   EXEC  | execute; memory ops issue their request here
//   WAIT  | memory request held until ram_ready
//   HALT  | all state frozen while halt_req is high
module nibbler_core
    import nibbler_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    nibbler_if.master         bus,
    input  logic [DATA_W-1:0] pushbuttons,
    output logic [DATA_W-1:0] ff_out,
    input  logic              halt_req,
    output logic              halted,
    output logic              phase,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        instr,
    output logic [ADDR_W-1:0] operand,
    output logic [DATA_W-1:0] accu,
    output logic              c_flag,
    output logic              z_flag
);

    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_EXEC  = ST_EXEC;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_HALT  = ST_HALT;

    logic [1:0]        state;
    opcode_e           op;
    logic              mem_op;
    logic              active;
    logic              retire;
    logic              taken;
    logic [DATA_W-1:0] src;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign op     = opcode_e'(instr);
    assign mem_op = is_mem(op);
    assign active = (state == S_EXEC) || (state == S_WAIT);
    assign retire = active && (!mem_op || bus.ram_ready);
    assign src    = mem_op ? bus.ram_rdata : operand[DATA_W-1:0];

    always_comb begin
        taken = 1'b0;
        if (is_jump(op)) begin
            case (op)
                OP_JC:   taken = c_flag;
                OP_JNC:  taken = !c_flag;
                OP_JZ:   taken = z_flag;
                OP_JNZ:  taken = !z_flag;
                default: taken = 1'b1;
            endcase
        end
    end

    assign pc_next = taken ? operand : pc + ADDR_W'(1);

    nibbler_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op_of(op)),
        .a      (accu),
        .b      (src),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Requests derive only from state and the latched instruction, so they
    // stay stable across WAIT and drop immediately on reset.
    assign bus.prog_addr = pc;
    assign bus.ram_addr  = operand;
    assign bus.ram_wdata = accu;
    assign bus.ram_re    = active && mem_op && (op != OP_ST);
    assign bus.ram_we    = active && (op == OP_ST);

    assign halted = (state == S_HALT);
    assign phase  = active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            accu    <= '0;
            ff_out  <= '0;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            instr   <= '0;
            operand <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    instr   <= bus.prog_word[ADDR_W+3:ADDR_W];
                    operand <= bus.prog_word[ADDR_W-1:0];
                    state   <= S_EXEC;
                end
                S_EXEC, S_WAIT: begin
                    if (retire) begin
                        pc    <= pc_next;
                        state <= halt_req ? S_HALT : S_FETCH;
                        case (op)
                            OP_CMPI, OP_CMPM: begin
                                c_flag <= alu_carry;
                                z_flag <= alu_zero;
                            end
                            OP_ADDI, OP_ADDM: begin
                                accu   <= alu_result;
                                c_flag <= alu_carry;
                                z_flag <= alu_zero;
                            end
                            OP_NORI, OP_NORM: begin
                                accu   <= alu_result;
                                z_flag <= alu_zero;
                            end
                            OP_LIT:  accu   <= operand[DATA_W-1:0];
                            OP_IN:   accu   <= pushbuttons;
                            OP_LD:   accu   <= bus.ram_rdata;
                            OP_OUT:  ff_out <= accu;
                            default: ;
                        endcase
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_HALT: begin
                    if (!halt_req)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_nibbler_core.sv
// Directed scoreboard bench for nibbler_core: program/RAM models, expected
// values queued with the stimulus and popped at each check point.
module tb_nibbler_core;

    localparam int DW = 4;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic [DW-1:0] pushbuttons;
    logic [DW-1:0] ff_out;
    logic          halt_req;
    logic          halted;
    logic          phase;
    logic [AW-1:0] pc;
    logic [3:0]    instr;
    logic [AW-1:0] operand;
    logic [DW-1:0] accu;
    logic          c_flag;
    logic          z_flag;
    logic          ram_ready_r;

    logic [AW+3:0] prog_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram      [0:(1<<AW)-1];

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          n_tests;
    int          n_fail;

    nibbler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    nibbler_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .pushbuttons (pushbuttons),
        .ff_out      (ff_out),
        .halt_req    (halt_req),
        .halted      (halted),
        .phase       (phase),
        .pc          (pc),
        .instr       (instr),
        .operand     (operand),
        .accu        (accu),
        .c_flag      (c_flag),
        .z_flag      (z_flag)
    );

    assign bus.prog_word = prog_mem[bus.prog_addr];
    assign bus.ram_rdata = ram[bus.ram_addr];
    assign bus.ram_ready = ram_ready_r;

    always @(posedge clk)
        if (bus.ram_we && bus.ram_ready)
            ram[bus.ram_addr] <= bus.ram_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed %0h required <none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", t, obs, e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            n_tests++;
            assert (!(bus.ram_re && bus.ram_we)) else begin
                n_fail++;
                $error("FAIL re_we_exclusive: observed re=%0b we=%0b required not both",
                       bus.ram_re, bus.ram_we);
            end
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < (1 << AW); i++) begin
            prog_mem[i] = 16'h4000;
            ram[i]      = '0;
        end
    endtask

    task automatic check_reset_state();
        push("rst_pc", 0);      push("rst_accu", 0);    push("rst_ff_out", 0);
        push("rst_c", 0);       push("rst_z", 0);       push("rst_instr", 0);
        push("rst_operand", 0); push("rst_ram_re", 0);  push("rst_ram_we", 0);
        push("rst_halted", 0);  push("rst_phase", 0);   push("rst_prog_addr", 0);
        check(pc);      check(accu);       check(ff_out);
        check(c_flag);  check(z_flag);     check(instr);
        check(operand); check(bus.ram_re); check(bus.ram_we);
        check(halted);  check(phase);      check(bus.prog_addr);
    endtask

    // Asserts reset off-edge, checks the async values, releases after one edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        halt_req    = 1'b0;
        pushbuttons = '0;
        ram_ready_r = 1'b1;
        #2;

        // LIT 9, ADDI 8: overflow into carry
        clear_prog();
        prog_mem[0] = 16'h4009;
        prog_mem[1] = 16'hA008;
        do_reset();
        push("t1_instr", 4'h4); push("t1_operand", 9); push("t1_phase", 1);
        step(1);
        check(instr); check(operand); check(phase);
        push("t1_accu", 1); push("t1_c", 1); push("t1_z", 0); push("t1_pc", 2);
        step(3);
        check(accu); check(c_flag); check(z_flag); check(pc);

        // compare, conditional jumps, NOR
        clear_prog();
        prog_mem[12'h000] = 16'h4005;
        prog_mem[12'h001] = 16'h2005;
        prog_mem[12'h002] = 16'h8020;
        prog_mem[12'h020] = 16'h0040;
        prog_mem[12'h040] = 16'h1100;
        prog_mem[12'h041] = 16'hE003;
        prog_mem[12'h042] = 16'hE007;
        do_reset();
        push("t2_z", 1); push("t2_c", 1); push("t2_pc", 12'h020); push("t2_accu", 5);
        step(6);
        check(z_flag); check(c_flag); check(pc); check(accu);
        push("t2_jc_pc", 12'h040);
        step(2);
        check(pc);
        push("t2_jnc_pc", 12'h041);
        step(2);
        check(pc);
        push("t2_nor1_accu", 8); push("t2_nor1_z", 0); push("t2_nor1_c", 1);
        step(2);
        check(accu); check(z_flag); check(c_flag);
        push("t2_nor2_accu", 0); push("t2_nor2_z", 1); push("t2_nor2_c", 1);
        step(2);
        check(accu); check(z_flag); check(c_flag);

        // store with wait states, then LD/ADDM/CMPM/IN/OUT
        clear_prog();
        prog_mem[0] = 16'h4006;
        prog_mem[1] = 16'h7003;
        prog_mem[2] = 16'h4000;
        prog_mem[3] = 16'h6003;
        prog_mem[4] = 16'hB003;
        prog_mem[5] = 16'h3003;
        prog_mem[6] = 16'h5000;
        prog_mem[7] = 16'hD000;
        ram_ready_r = 1'b0;
        pushbuttons = 4'hA;
        do_reset();
        push("t3_lit_accu", 6); push("t3_lit_pc", 1);
        step(2);
        check(accu); check(pc);
        push("t3_we0", 1); push("t3_re0", 0); push("t3_addr", 3); push("t3_wdata", 6);
        push("t3_phase", 1);
        step(1);
        check(bus.ram_we); check(bus.ram_re); check(bus.ram_addr); check(bus.ram_wdata);
        check(phase);
        for (int k = 1; k <= 3; k++) begin
            push("t3_we_wait", 1); push("t3_pc_wait", 1); push("t3_addr_wait", 3);
            step(1);
            if (k == 3) ram_ready_r = 1'b1;
            check(bus.ram_we); check(pc); check(bus.ram_addr);
        end
        push("t3_we_done", 0); push("t3_pc_done", 2); push("t3_ram3", 6);
        step(1);
        check(bus.ram_we); check(pc); check(ram[3]);
        push("t3_ld_re", 1); push("t3_ld_we", 0);
        step(3);
        check(bus.ram_re); check(bus.ram_we);
        push("t3_ld_accu", 6); push("t3_ld_pc", 4);
        step(1);
        check(accu); check(pc);
        push("t3_addm_accu", 4'hC); push("t3_addm_c", 0); push("t3_addm_z", 0);
        step(2);
        check(accu); check(c_flag); check(z_flag);
        push("t3_cmpm_accu", 4'hC); push("t3_cmpm_c", 1); push("t3_cmpm_z", 0);
        step(2);
        check(accu); check(c_flag); check(z_flag);
        push("t3_in_accu", 4'hA);
        step(2);
        check(accu);
        push("t3_out_ff", 4'hA);
        step(2);
        check(ff_out);

        // pc wrap from all-ones
        clear_prog();
        prog_mem[12'h000] = 16'hCFFF;
        prog_mem[12'hFFF] = 16'h4001;
        do_reset();
        push("t4_jmp_pc", 12'hFFF);
        step(2);
        check(pc);
        push("t4_wrap_pc", 0); push("t4_wrap_accu", 1);
        step(2);
        check(pc); check(accu);

        // halt requested during FETCH of OUT
        clear_prog();
        prog_mem[0] = 16'h4007;
        prog_mem[1] = 16'hD000;
        prog_mem[2] = 16'h4002;
        do_reset();
        step(2);
        halt_req = 1'b1;
        push("t5_exec_halted", 0); push("t5_exec_phase", 1); push("t5_exec_ff", 0);
        step(1);
        check(halted); check(phase); check(ff_out);
        push("t5_ff", 7); push("t5_halted", 1); push("t5_pc", 2);
        step(1);
        check(ff_out); check(halted); check(pc);
        push("t5_hold_halted", 1); push("t5_hold_pc", 2);
        step(2);
        check(halted); check(pc);
        halt_req = 1'b0;
        push("t5_exit_halted", 0); push("t5_exit_pc", 2);
        step(1);
        check(halted); check(pc);
        push("t5_resume_accu", 2); push("t5_resume_pc", 3);
        step(2);
        check(accu); check(pc);

        // reset in the middle of an LD wait
        clear_prog();
        prog_mem[0] = 16'h4003;
        prog_mem[1] = 16'hD000;
        prog_mem[2] = 16'h6005;
        ram_ready_r = 1'b0;
        do_reset();
        push("t6_accu", 3); push("t6_ff", 3); push("t6_pc", 2);
        step(4);
        check(accu); check(ff_out); check(pc);
        push("t6_re_wait", 1);
        step(2);
        check(bus.ram_re);
        #2;
        do_reset();
        push("t6_first_addr", 0);
        check(bus.prog_addr);
        push("t6_refetch_instr", 4); push("t6_refetch_operand", 3);
        step(1);
        check(instr); check(operand);
        ram_ready_r = 1'b1;

        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
